// File: rtl/basicreg_ser.sv
// Parallel-to-serial transmit register: accepts a WIDTH-bit word over valid/ready
// and emits it one bit per clock with registered q / q_valid / q_last.
module basicreg_ser #(
    parameter int WIDTH     = 32'sd3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_last
);

    localparam int            CW       = (WIDTH > 32'sd1) ? $clog2(WIDTH) : 32'sd1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 32'sd1);
    localparam logic          SINGLE   = (WIDTH == 32'sd1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             q_last_q, q_last_d;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    cnt_nxt;
    logic             at_last;
    logic             xfer;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 32'sd0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-32'sd1-i];
        end
        return r;
    endfunction

    // sr always holds the not-yet-sent bits in transmit order, LSB next.
    assign load_word = MSB_FIRST ? bit_reverse(d) : d;
    assign at_last   = (cnt_q == LAST_CNT);
    assign cnt_nxt   = cnt_q + CW'(1'b1);
    assign d_ready   = ~rst & ((state_q == IDLE) | at_last);
    assign xfer      = d_valid & d_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = xfer ? SHIFT : IDLE;
            SHIFT:   state_d = (at_last && !xfer) ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; a load on the last-bit cycle gives gapless words.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        q_d       = 1'b0;
        q_valid_d = 1'b0;
        q_last_d  = 1'b0;
        if (xfer) begin
            sr_d      = load_word >> 32'd1;
            cnt_d     = {CW{1'b0}};
            q_d       = load_word[0];
            q_valid_d = 1'b1;
            q_last_d  = SINGLE;
        end else if ((state_q == SHIFT) && !at_last) begin
            sr_d      = sr_q >> 32'd1;
            cnt_d     = cnt_nxt;
            q_d       = sr_q[0];
            q_valid_d = 1'b1;
            q_last_d  = (cnt_nxt == LAST_CNT);
        end else begin
            q_d       = 1'b0;
            q_valid_d = 1'b0;
            q_last_d  = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_last  = q_last_q;

endmodule

// File: tb/tb_basicreg_ser.sv
// Bench for basicreg_ser: a 3-bit LSB-first and a 4-bit MSB-first instance against
// a bit-queue reference model plus a loopback reassembly scoreboard.
module tb_basicreg_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] d_a;
    logic       dv_a, rdy_a, q_a, qv_a, ql_a;
    logic [3:0] d_b;
    logic       dv_b, rdy_b, q_b, qv_b, ql_b;

    basicreg_ser #(.WIDTH(3), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .d(d_a), .d_valid(dv_a), .d_ready(rdy_a),
        .q(q_a), .q_valid(qv_a), .q_last(ql_a)
    );

    basicreg_ser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .d(d_b), .d_valid(dv_b), .d_ready(rdy_b),
        .q(q_b), .q_valid(qv_b), .q_last(ql_b)
    );

    int checks   = 0;
    int failures = 0;

    int          w   [2] = '{3, 4};
    bit          msb [2] = '{1'b0, 1'b1};
    int          left[2];
    logic [31:0] rest[2];
    logic        eq[2], ev[2], el[2];
    logic [31:0] asm_w[2];
    int          nb[2];
    logic [31:0] sent_a[$];
    logic [31:0] sent_b[$];
    logic [31:0] stream_a, stream_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word bits rearranged so that position i is the i-th bit on the wire.
    function automatic logic [31:0] wire_order(input logic [31:0] v, input int width, input bit m);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < width; i++) r[i] = m ? v[width-1-i] : v[i];
        return r;
    endfunction

    task automatic cycle();
        logic [1:0]  rdy_exp;
        logic        dvk, oq, ov, ol;
        logic [31:0] ddk, word, expw;
        #1;
        for (int k = 0; k < 2; k++) rdy_exp[k] = !rst && (left[k] == 0);
        check("d_ready[0]", 32'(rdy_a), 32'(rdy_exp[0]));
        check("d_ready[1]", 32'(rdy_b), 32'(rdy_exp[1]));
        for (int k = 0; k < 2; k++) begin
            dvk = (k == 0) ? dv_a : dv_b;
            ddk = (k == 0) ? 32'(d_a) : 32'(d_b);
            if (rst) begin
                left[k] = 0; rest[k] = 32'h0;
                eq[k] = 1'b0; ev[k] = 1'b0; el[k] = 1'b0;
                asm_w[k] = 32'h0; nb[k] = 0;
                if (k == 0) sent_a.delete(); else sent_b.delete();
            end else if (rdy_exp[k] && dvk) begin
                word    = wire_order(ddk, w[k], msb[k]);
                eq[k]   = word[0];
                ev[k]   = 1'b1;
                left[k] = w[k] - 1;
                rest[k] = word >> 1;
                el[k]   = (left[k] == 0);
                if (k == 0) sent_a.push_back(ddk); else sent_b.push_back(ddk);
            end else if (left[k] > 0) begin
                word    = rest[k];
                eq[k]   = word[0];
                rest[k] = rest[k] >> 1;
                left[k] = left[k] - 1;
                ev[k]   = 1'b1;
                el[k]   = (left[k] == 0);
            end else begin
                eq[k] = 1'b0; ev[k] = 1'b0; el[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            oq = (k == 0) ? q_a  : q_b;
            ov = (k == 0) ? qv_a : qv_b;
            ol = (k == 0) ? ql_a : ql_b;
            check($sformatf("q[%0d]", k), 32'(oq), 32'(eq[k]));
            check($sformatf("q_valid[%0d]", k), 32'(ov), 32'(ev[k]));
            check($sformatf("q_last[%0d]", k), 32'(ol), 32'(el[k]));
            if (ov) begin
                if (msb[k]) asm_w[k] = (asm_w[k] << 1) | 32'(oq);
                else        asm_w[k] = asm_w[k] | (32'(oq) << nb[k]);
                nb[k]++;
                if (k == 0) stream_a = {stream_a[30:0], oq};
                else        stream_b = {stream_b[30:0], oq};
            end
            if (ov && ol) begin
                expw = 32'hDEAD_BEEF;
                if (k == 0 && sent_a.size() > 0) expw = sent_a.pop_front();
                if (k == 1 && sent_b.size() > 0) expw = sent_b.pop_front();
                check($sformatf("loopback_word[%0d]", k), asm_w[k], expw);
                check($sformatf("loopback_len[%0d]", k), 32'(nb[k]), 32'(w[k]));
                asm_w[k] = 32'h0;
                nb[k]    = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; rest[k] = 32'h0; asm_w[k] = 32'h0; nb[k] = 0;
        end
        stream_a = 32'h0;
        stream_b = 32'h0;

        // Reset held with a pending word that must not be taken.
        rst = 1'b1; dv_a = 1'b1; d_a = 3'b111; dv_b = 1'b1; d_b = 4'hF;
        cycle();
        cycle();
        check("rst_q", 32'(q_a), 32'h0);
        check("rst_q_valid", 32'(qv_a), 32'h0);
        check("rst_q_last", 32'(ql_a), 32'h0);
        check("rst_d_ready", 32'(rdy_a), 32'h0);
        rst = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
        cycle();
        check("post_rst_d_ready", 32'(rdy_a), 32'h1);

        // Single word, LSB first.
        stream_a = 32'h0; d_a = 3'b101; dv_a = 1'b1;
        cycle();
        dv_a = 1'b0; d_a = 3'b000;
        repeat (4) cycle();
        check("single_stream", stream_a, 32'b101);

        // Back-to-back words with d_valid held; d changes while busy.
        stream_a = 32'h0; dv_a = 1'b1; d_a = 3'b110;
        cycle();
        d_a = 3'b011;
        repeat (3) cycle();
        dv_a = 1'b0; d_a = 3'b111;
        repeat (4) cycle();
        check("b2b_stream", stream_a, 32'b011110);

        // Busy hold: second request arrives one cycle after a transfer.
        stream_a = 32'h0; dv_a = 1'b1; d_a = 3'b001;
        cycle();
        dv_a = 1'b0;
        cycle();
        dv_a = 1'b1; d_a = 3'b100;
        repeat (3) cycle();
        dv_a = 1'b0; d_a = 3'b010;
        repeat (4) cycle();
        check("busy_stream", stream_a, 32'b100001);

        // MSB-first, 4-bit instance.
        stream_b = 32'h0; d_b = 4'b1000; dv_b = 1'b1;
        cycle();
        dv_b = 1'b0; d_b = 4'b0111;
        repeat (5) cycle();
        check("msb_stream", stream_b, 32'b1000);

        // Reset after the second bit of a word, then a clean word.
        d_a = 3'b111; dv_a = 1'b1;
        cycle();
        dv_a = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_q_valid", 32'(qv_a), 32'h0);
        rst = 1'b0; stream_a = 32'h0; d_a = 3'b010; dv_a = 1'b1;
        cycle();
        dv_a = 1'b0;
        repeat (4) cycle();
        check("midrst_stream", stream_a, 32'b010);

        // Randomized traffic with occasional resets.
        repeat (400) begin
            rst  = ($urandom_range(0, 39) == 0);
            dv_a = 1'($urandom_range(0, 1));
            dv_b = 1'($urandom_range(0, 1));
            d_a  = 3'($urandom());
            d_b  = 4'($urandom());
            cycle();
        end
        rst = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
